// File: rtl/xor_bist_ctrl.sv
// Purpose: BIST sequencer that sweeps every {a,b} pattern through an external XOR and checks y against a^b.
// Latency: WIDTH-dependent run of 2^(2*WIDTH)*SETTLE cycles from accepted start to done.
// Backpressure: none; start is ignored while busy, abort cancels a run at any time.
module xor_bist_ctrl #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    input  logic [WIDTH-1:0]   dut_y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    localparam int PW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;
    localparam logic [PW-1:0] PAT_LAST  = {PW{1'b1}};
    localparam logic [3:0]    WAIT_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   pat;
    logic [3:0]      wait_cnt;
    logic            sample;
    logic            mismatch;
    logic            accept_start;

    // start is honoured only outside a run, and never in the same cycle as abort
    assign accept_start = start && !abort && (state != ST_RUN);
    // the last settle cycle of each pattern is the sample edge
    assign sample       = (state == ST_RUN) && (wait_cnt == WAIT_LAST);
    assign mismatch     = (dut_y != (dut_a ^ dut_b));

    assign dut_a = pat[PW-1:WIDTH];
    assign dut_b = pat[WIDTH-1:0];
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);
    assign pass  = done && (err_count == '0);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: abort dominates, run ends on the sample of the last pattern
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sample && (pat == PAT_LAST)) begin
                        state_nxt = ST_DONE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // pattern sweep, settle counting, error tally and first-failure capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat        <= '0;
            wait_cnt   <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else if (abort) begin
            // results of the cancelled run stay visible for debug
            pat      <= '0;
            wait_cnt <= '0;
        end else if (accept_start) begin
            pat        <= '0;
            wait_cnt   <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else if (state == ST_RUN) begin
            if (sample) begin
                wait_cnt <= '0;
                // wraps to 0 after the last pattern, parking the operands at 0 in DONE
                pat      <= pat + PW'(1);
                if (mismatch) begin
                    err_count <= err_count + EW'(1);
                    if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= dut_a;
                        fail_b     <= dut_b;
                    end
                end
            end else begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_xor_bist_ctrl.sv
module tb_xor_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         errors = 0;
    int         mode = 0;   // 0: correct XOR, 1: y tied 0, 2: XNOR

    // instance 1: WIDTH=1, SETTLE=2
    logic       start1, abort1;
    logic [0:0] a1, b1, y1, fa1, fb1;
    logic       busy1, done1, pass1, fv1;
    logic [2:0] err1;

    // instance 2: WIDTH=2, SETTLE=1
    logic       start2, abort2;
    logic [1:0] a2, b2, y2, fa2, fb2;
    logic       busy2, done2, pass2, fv2;
    logic [4:0] err2;

    always #5 clk = ~clk;

    assign y1 = (mode == 0) ? (a1 ^ b1) : (mode == 1) ? 1'b0 : ~(a1 ^ b1);
    assign y2 = a2 ^ b2;

    xor_bist_ctrl #(.WIDTH(1), .SETTLE(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .dut_a(a1), .dut_b(b1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
    );

    xor_bist_ctrl #(.WIDTH(2), .SETTLE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .dut_a(a2), .dut_b(b2), .dut_y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done1();
        for (int i = 0; i < 40; i++) begin
            if (done1) break;
            tick();
        end
        chk("done1_wait", 32'(done1), 32'd1);
    endtask

    task automatic check_zero1(input string tag);
        chk({tag, "_busy"}, 32'(busy1), 32'd0);
        chk({tag, "_done"}, 32'(done1), 32'd0);
        chk({tag, "_pass"}, 32'(pass1), 32'd0);
        chk({tag, "_err"},  32'(err1),  32'd0);
        chk({tag, "_fv"},   32'(fv1),   32'd0);
        chk({tag, "_fab"},  32'({fa1, fb1}), 32'd0);
        chk({tag, "_ab"},   32'({a1, b1}),   32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check_zero1("rst");
        chk("rst_u2_busy", 32'(busy2), 32'd0);
        chk("rst_u2_err",  32'(err2),  32'd0);

        // correct model, W=1 S=2: busy after edges 0..7, done after edge 8
        mode = 0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("t1_busy_e0", 32'(busy1), 32'd1);
        chk("t1_ab_e0", 32'({a1, b1}), 32'd0);
        for (int j = 1; j < 8; j++) begin
            tick();
            chk("t1_busy", 32'(busy1), 32'd1);
            chk("t1_ab", 32'({a1, b1}), 32'(j / 2));
        end
        tick();
        chk("t1_done", 32'(done1), 32'd1);
        chk("t1_pass", 32'(pass1), 32'd1);
        chk("t1_busy_end", 32'(busy1), 32'd0);
        chk("t1_err", 32'(err1), 32'd0);
        chk("t1_fv", 32'(fv1), 32'd0);
        chk("t1_ab_end", 32'({a1, b1}), 32'd0);

        // y stuck at 0: patterns 01 and 10 fail, first is a=0 b=1
        mode = 1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("t2_done_clr", 32'(done1), 32'd0);
        wait_done1();
        chk("t2_err", 32'(err1), 32'd2);
        chk("t2_fv", 32'(fv1), 32'd1);
        chk("t2_fa", 32'(fa1), 32'd0);
        chk("t2_fb", 32'(fb1), 32'd1);
        chk("t2_pass", 32'(pass1), 32'd0);

        // XNOR: every pattern fails, first is a=0 b=0
        mode = 2;
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("t3_err_clr", 32'(err1), 32'd0);
        wait_done1();
        chk("t3_err", 32'(err1), 32'd4);
        chk("t3_fv", 32'(fv1), 32'd1);
        chk("t3_fab", 32'({fa1, fb1}), 32'd0);
        chk("t3_pass", 32'(pass1), 32'd0);

        // rerun from failing DONE with a correct model
        mode = 0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("t4_fv_clr", 32'(fv1), 32'd0);
        wait_done1();
        chk("t4_pass", 32'(pass1), 32'd1);
        chk("t4_fv", 32'(fv1), 32'd0);
        chk("t4_err", 32'(err1), 32'd0);

        // start re-pulsed mid-run is ignored: sweep continues, run length unchanged
        start1 = 1'b1; tick(); start1 = 1'b0;
        tick(); tick();
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("t5_ab_e3", 32'({a1, b1}), 32'd1);
        tick();
        chk("t5_ab_e4", 32'({a1, b1}), 32'd2);
        tick(); tick(); tick();
        chk("t5_busy_e7", 32'(busy1), 32'd1);
        tick();
        chk("t5_done_e8", 32'(done1), 32'd1);

        // abort at edge 3 of a failing run: back to IDLE, results kept
        mode = 2;
        start1 = 1'b1; tick(); start1 = 1'b0;
        tick(); tick();
        abort1 = 1'b1; tick(); abort1 = 1'b0;
        chk("t6_busy", 32'(busy1), 32'd0);
        chk("t6_done", 32'(done1), 32'd0);
        chk("t6_ab", 32'({a1, b1}), 32'd0);
        chk("t6_err", 32'(err1), 32'd1);
        chk("t6_fv", 32'(fv1), 32'd1);
        tick();
        chk("t6_idle", 32'(busy1), 32'd0);

        // start and abort together: abort wins
        start1 = 1'b1; abort1 = 1'b1; tick(); start1 = 1'b0; abort1 = 1'b0;
        chk("t7_busy", 32'(busy1), 32'd0);
        chk("t7_err_kept", 32'(err1), 32'd1);

        // reset at edge 5 of a run discards everything
        start1 = 1'b1; tick(); start1 = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t8_err_pre", 32'(err1), 32'd2);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check_zero1("t8");

        // W=2 S=1: patterns 0..15 in order, done after edge 16
        start2 = 1'b1; tick(); start2 = 1'b0;
        chk("t9_ab_e0", 32'({a2, b2}), 32'd0);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("t9_ab", 32'({a2, b2}), 32'(k));
            chk("t9_busy", 32'(busy2), 32'd1);
        end
        tick();
        chk("t9_done", 32'(done2), 32'd1);
        chk("t9_pass", 32'(pass2), 32'd1);
        chk("t9_err", 32'(err2), 32'd0);
        chk("t9_fv", 32'(fv2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
